// File: rtl/traffic_display_scanner_pkg.sv
// ============================================================================
// Module      : traffic_display_scanner_pkg
// Description : Shared constants for the multiplexed 7-segment display scanner
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_display_scanner_pkg;

    localparam int c_digit_count   = 4;
    localparam int c_segment_width = 7;
    localparam int c_display_width = 14;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    localparam logic [3:0] c_sel_slot0 = 4'b1110;
    localparam logic [3:0] c_sel_slot1 = 4'b1101;
    localparam logic [3:0] c_sel_slot2 = 4'b1011;
    localparam logic [3:0] c_sel_slot3 = 4'b0111;
    localparam logic [3:0] c_sel_none  = 4'b1111;

    // Segment patterns, bit order gfedcba, active-high
    localparam logic [6:0] c_seg_0 = 7'b0111111;
    localparam logic [6:0] c_seg_1 = 7'b0000110;
    localparam logic [6:0] c_seg_2 = 7'b1011011;
    localparam logic [6:0] c_seg_3 = 7'b1001111;
    localparam logic [6:0] c_seg_4 = 7'b1100110;
    localparam logic [6:0] c_seg_5 = 7'b1101101;
    localparam logic [6:0] c_seg_6 = 7'b1111101;
    localparam logic [6:0] c_seg_7 = 7'b0000111;
    localparam logic [6:0] c_seg_8 = 7'b1111111;
    localparam logic [6:0] c_seg_9 = 7'b1101111;

    function automatic logic [3:0] slot_select(input logic [1:0] slot);
        case (slot)
            2'd0:    return c_sel_slot0;
            2'd1:    return c_sel_slot1;
            2'd2:    return c_sel_slot2;
            default: return c_sel_slot3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_display_scanner_digit_slot_counter.sv
// ============================================================================
// Module      : digit_slot_counter
// Description : Tick-within-slot and slot-within-frame counters with terminals
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_slot_counter #(
    parameter int TICKS_PER_DIGIT = 4,
    parameter int TICK_WIDTH      = $clog2(TICKS_PER_DIGIT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [TICK_WIDTH-1:0] o_tick,
    output logic [1:0]            o_slot,
    output logic                  o_tick_last,
    output logic                  o_frame_last
);

    localparam logic [TICK_WIDTH-1:0] c_tick_last = TICK_WIDTH'(TICKS_PER_DIGIT - 1);

    logic [TICK_WIDTH-1:0] r_tick;
    logic [1:0]            r_slot;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= '0;
            r_slot <= 2'd0;
        end else if (i_clear) begin
            r_tick <= '0;
            r_slot <= 2'd0;
        end else if (i_advance) begin
            if (r_tick == c_tick_last) begin
                r_tick <= '0;
                r_slot <= r_slot + 2'd1;
            end else begin
                r_tick <= r_tick + TICK_WIDTH'(1);
            end
        end
    end

    assign o_tick       = r_tick;
    assign o_slot       = r_slot;
    assign o_tick_last  = (r_tick == c_tick_last);
    assign o_frame_last = (r_tick == c_tick_last) && (r_slot == 2'd3);

endmodule

`default_nettype wire

// File: rtl/traffic_display_scanner.sv
// ============================================================================
// Module      : traffic_display_scanner
// Description : Scans row/column countdown digits onto a 4-digit muxed panel
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_display_scanner
    import traffic_display_scanner_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 4,
    parameter int BLANK_TICKS     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [13:0] row_display,
    input  logic [13:0] column_display,
    output logic [6:0]  segment,
    output logic [3:0]  digit_select,
    output logic        frame_start
);

    localparam int c_tick_width = $clog2(TICKS_PER_DIGIT);
    localparam logic [c_tick_width-1:0] c_blank_last = c_tick_width'(BLANK_TICKS - 1);

    generate
        if (TICKS_PER_DIGIT < 2 || BLANK_TICKS < 1 || BLANK_TICKS > TICKS_PER_DIGIT - 1) begin : g_bad_params
            $fatal(1, "traffic_display_scanner: illegal TICKS_PER_DIGIT/BLANK_TICKS");
        end
    endgenerate

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [13:0]             r_row_shadow;
    logic [13:0]             r_col_shadow;
    logic [c_tick_width-1:0] w_tick;
    logic [1:0]              w_slot;
    logic                    w_tick_last;
    logic                    w_frame_last;
    logic                    w_clear;
    logic                    w_advance;
    logic                    w_load;
    logic [1:0]              w_next_slot;
    logic [6:0]              w_seg_next;
    logic [3:0]              w_sel_next;
    logic [6:0]              r_segment;
    logic [3:0]              r_digit_select;
    logic                    r_frame_start;

    digit_slot_counter #(
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .TICK_WIDTH      (c_tick_width)
    ) u_counter (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_clear      (w_clear),
        .i_advance    (w_advance),
        .o_tick       (w_tick),
        .o_slot       (w_slot),
        .o_tick_last  (w_tick_last),
        .o_frame_last (w_frame_last)
    );

    always_comb begin
        w_next_state = c_st_idle;
        w_load       = 1'b0;
        w_clear      = 1'b1;
        w_advance    = 1'b0;
        w_next_slot  = 2'd0;
        if (enable) begin
            case (r_state)
                c_st_idle: begin
                    w_next_state = c_st_blank;
                    w_load       = 1'b1;
                end
                c_st_blank: begin
                    w_clear      = 1'b0;
                    w_advance    = 1'b1;
                    w_next_slot  = w_slot;
                    w_next_state = (w_tick == c_blank_last) ? c_st_show : c_st_blank;
                end
                c_st_show: begin
                    w_clear     = 1'b0;
                    w_advance   = 1'b1;
                    w_next_slot = w_slot;
                    if (w_tick_last) begin
                        w_next_state = c_st_blank;
                        w_next_slot  = w_slot + 2'd1;
                        w_load       = w_frame_last;
                    end else begin
                        w_next_state = c_st_show;
                    end
                end
                default: w_next_state = c_st_idle;
            endcase
        end
    end

    // SHOW is only ever entered from BLANK, so the shadow is already settled
    always_comb begin
        w_seg_next = 7'b0;
        w_sel_next = c_sel_none;
        if (w_next_state == c_st_show) begin
            w_sel_next = slot_select(w_next_slot);
            case (w_next_slot)
                2'd0:    w_seg_next = r_row_shadow[13:7];
                2'd1:    w_seg_next = r_row_shadow[6:0];
                2'd2:    w_seg_next = r_col_shadow[13:7];
                default: w_seg_next = r_col_shadow[6:0];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= c_st_idle;
            r_row_shadow   <= '0;
            r_col_shadow   <= '0;
            r_segment      <= 7'b0;
            r_digit_select <= c_sel_none;
            r_frame_start  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_segment      <= w_seg_next;
            r_digit_select <= w_sel_next;
            r_frame_start  <= w_load;
            if (w_load) begin
                r_row_shadow <= row_display;
                r_col_shadow <= column_display;
            end
        end
    end

    assign segment      = r_segment;
    assign digit_select = r_digit_select;
    assign frame_start  = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_traffic_display_scanner.sv
// ============================================================================
// Module      : tb_traffic_display_scanner
// Description : Directed self-checking bench for traffic_display_scanner
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_display_scanner;
    import traffic_display_scanner_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [13:0] row_display = '0;
    logic [13:0] column_display = '0;
    logic [6:0]  segment, segment_alt;
    logic [3:0]  digit_select, digit_select_alt;
    logic        frame_start, frame_start_alt;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc;
    logic [6:0]  exp_pat [4];
    logic [3:0]  last_lit;
    int          blank_run;

    always #5 clock = ~clock;

    traffic_display_scanner dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .row_display    (row_display),
        .column_display (column_display),
        .segment        (segment),
        .digit_select   (digit_select),
        .frame_start    (frame_start)
    );

    traffic_display_scanner #(
        .TICKS_PER_DIGIT (6),
        .BLANK_TICKS     (2)
    ) dut_alt (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .row_display    (row_display),
        .column_display (column_display),
        .segment        (segment_alt),
        .digit_select   (digit_select_alt),
        .frame_start    (frame_start_alt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {frame_start, digit_select, segment} for cycle c of a run
    function automatic logic [11:0] model(input int c, input int t, input int b);
        int k;
        int slot;
        int tick;
        logic fs;
        logic [3:0] sel;
        k    = c - 1;
        slot = (k / t) % 4;
        tick = k % t;
        fs   = ((k % (4 * t)) == 0);
        sel  = ~(4'b0001 << slot);
        if (tick < b) return {fs, 4'b1111, 7'b0};
        return {fs, sel, exp_pat[slot]};
    endfunction

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            cyc++;
            chk($sformatf("scan c%0d", cyc), {20'b0, frame_start, digit_select, segment},
                {20'b0, model(cyc, 4, 1)});
        end
    endtask

    task automatic run_alt(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            cyc++;
            chk($sformatf("alt c%0d", cyc), {20'b0, frame_start_alt, digit_select_alt, segment_alt},
                {20'b0, model(cyc, 6, 2)});
            if (digit_select_alt == 4'b1111) begin
                blank_run++;
            end else begin
                if (last_lit != 4'b1111 && last_lit != digit_select_alt)
                    chk($sformatf("gap c%0d", cyc), 32'(blank_run >= 2), 32'd1);
                blank_run = 0;
                last_lit  = digit_select_alt;
            end
        end
    endtask

    initial begin
        // Power-up reset, then hold for three edges
        #1 reset = 1'b0;
        #2 chk("rst_async", {20'b0, frame_start, digit_select, segment}, 32'h780);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_hold", {20'b0, frame_start, digit_select, segment}, 32'h780);
        end

        // Full-frame scan: row 25, column 10
        row_display    = {c_seg_2, c_seg_5};
        column_display = {c_seg_1, c_seg_0};
        exp_pat        = '{c_seg_2, c_seg_5, c_seg_1, c_seg_0};
        enable = 1'b1;
        reset  = 1'b1;
        cyc    = 0;
        run(48);

        // Snapshot isolation: row -> 24 during slot 1 of frame starting at 49
        run(5);
        row_display = {c_seg_2, c_seg_4};
        run(11);
        exp_pat[1] = c_seg_4;
        run(16);

        // Enable gating during slot 2 SHOW; new column taken on re-enable
        run(10);
        enable = 1'b0;
        column_display = {c_seg_3, c_seg_7};
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("disabled", {20'b0, frame_start, digit_select, segment}, 32'h780);
        end
        enable = 1'b1;
        exp_pat[2] = c_seg_3;
        exp_pat[3] = c_seg_7;
        cyc = 0;
        run(16);

        // Reset asserted mid-cycle during SHOW slot 3
        run(14);
        chk("pre_rst_lit", {28'b0, digit_select}, {28'b0, c_sel_slot3});
        #3 reset = 1'b0;
        #1 chk("rst_mid", {20'b0, frame_start, digit_select, segment}, 32'h780);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("rst_mid_hold", {20'b0, frame_start, digit_select, segment}, 32'h780);
        end
        reset = 1'b1;
        cyc = 0;
        run(16);

        // Non-default parameters: 6 ticks per slot, 2 blank
        reset = 1'b0;
        @(posedge clock); #1;
        reset     = 1'b1;
        cyc       = 0;
        last_lit  = 4'b1111;
        blank_run = 0;
        run_alt(48);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
